key_event_decoder: RTL and testbench

Converts the clean, debounced level of one push-button into single-cycle key events: press, release, single click, double click, long press, and auto-repeat. It sits directly downstream of the per-key debounce stage in the video_processing key path. Its event pulses drive the camera control logic: mode select, parameter step up/down, and hold-to-scroll.

---
 rtl/key_event_decoder.sv | 166 ++++++++++++++++
 tb/tb_key_event_decoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_decoder.sv
// -----------------------------------------------------------------------------
// key_event_decoder
//
// Turns the debounced level of one push-button into single-cycle key events:
// press, release, single click, double click, long press and auto-repeat.
//
// Ports:
//   clk         in   system clock, single domain
//   rst_n       in   asynchronous active-low reset
//   in          in   debounced key level, synchronous to clk
//   press       out  one-cycle pulse on every press edge
//   release_ev  out  one-cycle pulse on every release edge
//   click       out  one-cycle pulse: short single press, confirmed after gap
//   dbl_click   out  one-cycle pulse on release of a short second press
//   long_press  out  one-cycle pulse when a hold reaches LONG_CYCLES
//   repeat_ev   out  one-cycle pulse every REPEAT_CYCLES after long_press
//   held        out  level: key currently pressed as seen by the FSM
// -----------------------------------------------------------------------------
module key_event_decoder #(
    parameter logic PRESS_LEVEL   = 1'b0,
    parameter int   CNT_BITS      = 25,
    parameter int   LONG_CYCLES   = 25_000_000,
    parameter int   REPEAT_CYCLES = 5_000_000,
    parameter int   GAP_CYCLES    = 12_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic press,
    output logic release_ev,
    output logic click,
    output logic dbl_click,
    output logic long_press,
    output logic repeat_ev,
    output logic held
);

    localparam logic [CNT_BITS-1:0] LONG_LAST   = CNT_BITS'(LONG_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] REPEAT_LAST = CNT_BITS'(REPEAT_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] GAP_LAST    = CNT_BITS'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRESS1 = 3'd1,
        S_LONG   = 3'd2,
        S_GAP    = 3'd3,
        S_PRESS2 = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_BITS-1:0] cnt;
    logic                smp_p0;
    logic                lvl;
    logic                rise;
    logic                fall;
    logic                press_nxt;
    logic                release_nxt;
    logic                click_nxt;
    logic                dbl_nxt;
    logic                long_nxt;
    logic                repeat_nxt;

    // ---- stage 0: sample the key, then keep the previous sample in lvl ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_p0 <= 1'b0;
            lvl    <= 1'b0;
        end else begin
            smp_p0 <= (in == PRESS_LEVEL);
            lvl    <= smp_p0;
        end
    end

    assign rise = smp_p0 & ~lvl;
    assign fall = ~smp_p0 & lvl;

    // ---- stage 1: FSM state register and shared cycle counter ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter restarts on every state change and on each repeat reload; it is
    // parked at zero in IDLE so it can never run up to its maximum there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if ((state_nxt != state) || repeat_nxt || (state_nxt == S_IDLE)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Edges are tested before counter expiries so an edge always wins a tie.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (rise) state_nxt = S_PRESS1;
            S_PRESS1: if (fall) state_nxt = S_GAP;
                      else if (cnt == LONG_LAST) state_nxt = S_LONG;
            S_LONG:   if (fall) state_nxt = S_IDLE;
            S_GAP:    if (rise) state_nxt = S_PRESS2;
                      else if (cnt == GAP_LAST) state_nxt = S_IDLE;
            S_PRESS2: if (fall) state_nxt = S_IDLE;
                      else if (cnt == LONG_LAST) state_nxt = S_LONG;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        click_nxt   = 1'b0;
        dbl_nxt     = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;
        case (state)
            S_IDLE:   press_nxt = rise;
            S_PRESS1: begin
                release_nxt = fall;
                long_nxt    = ~fall && (cnt == LONG_LAST);
            end
            S_LONG:   begin
                release_nxt = fall;
                repeat_nxt  = ~fall && (cnt == REPEAT_LAST);
            end
            S_GAP:    begin
                press_nxt = rise;
                click_nxt = ~rise && (cnt == GAP_LAST);
            end
            S_PRESS2: begin
                release_nxt = fall;
                dbl_nxt     = fall;
                long_nxt    = ~fall && (cnt == LONG_LAST);
            end
            default:  ;
        endcase
    end

    // ---- stage 2: registered event pulses ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press      <= 1'b0;
            release_ev <= 1'b0;
            click      <= 1'b0;
            dbl_click  <= 1'b0;
            long_press <= 1'b0;
            repeat_ev  <= 1'b0;
        end else begin
            press      <= press_nxt;
            release_ev <= release_nxt;
            click      <= click_nxt;
            dbl_click  <= dbl_nxt;
            long_press <= long_nxt;
            repeat_ev  <= repeat_nxt;
        end
    end

    assign held = (state == S_PRESS1) || (state == S_LONG) || (state == S_PRESS2);

endmodule

// File: tb/tb_key_event_decoder.sv
module tb_key_event_decoder;

    localparam int LONG   = 16;
    localparam int REPEAT = 4;
    localparam int GAP    = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic in;
    logic press, release_ev, click, dbl_click, long_press, repeat_ev, held;

    int errors = 0;
    int checks = 0;

    key_event_decoder #(
        .PRESS_LEVEL  (1'b0),
        .CNT_BITS     (5),
        .LONG_CYCLES  (LONG),
        .REPEAT_CYCLES(REPEAT),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .press     (press),
        .release_ev(release_ev),
        .click     (click),
        .dbl_click (dbl_click),
        .long_press(long_press),
        .repeat_ev (repeat_ev),
        .held      (held)
    );

    always #5 clk = ~clk;

    // Reference model: key history plus "what phase are we in and since when".
    typedef enum int { M_IDLE, M_FIRST, M_LONG, M_GAP, M_SECOND } mphase_t;
    mphase_t   m_phase;
    int        m_now;
    int        m_since;
    bit        m_hist0;   // key pressed as seen one edge ago
    bit        m_hist1;   // key pressed as seen two edges ago
    logic [6:0] exp_v;    // {press, release, click, dbl, long, repeat, held}

    int n_press, n_rel, n_click, n_dbl, n_long, n_rpt;

    task automatic model_reset();
        m_phase = M_IDLE;
        m_now   = 0;
        m_since = 0;
        m_hist0 = 0;
        m_hist1 = 0;
        exp_v   = '0;
    endtask

    // Called right after each rising clock edge.
    task automatic model_edge();
        bit went_down, went_up;
        bit e_p, e_r, e_c, e_d, e_l, e_t;
        int age;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_now++;
        went_down = m_hist0 && !m_hist1;
        went_up   = !m_hist0 && m_hist1;
        age = m_now - m_since;
        {e_p, e_r, e_c, e_d, e_l, e_t} = '0;
        case (m_phase)
            M_IDLE:   if (went_down) begin e_p = 1; m_phase = M_FIRST; m_since = m_now; end
            M_FIRST:  if (went_up) begin e_r = 1; m_phase = M_GAP; m_since = m_now; end
                      else if (age == LONG) begin e_l = 1; m_phase = M_LONG; m_since = m_now; end
            M_LONG:   if (went_up) begin e_r = 1; m_phase = M_IDLE; end
                      else if (age == REPEAT) begin e_t = 1; m_since = m_now; end
            M_GAP:    if (went_down) begin e_p = 1; m_phase = M_SECOND; m_since = m_now; end
                      else if (age == GAP) begin e_c = 1; m_phase = M_IDLE; end
            M_SECOND: if (went_up) begin e_r = 1; e_d = 1; m_phase = M_IDLE; end
                      else if (age == LONG) begin e_l = 1; m_phase = M_LONG; m_since = m_now; end
            default:  ;
        endcase
        m_hist1 = m_hist0;
        m_hist0 = (in == 1'b0);
        exp_v = {e_p, e_r, e_c, e_d, e_l, e_t,
                 (m_phase == M_FIRST) || (m_phase == M_LONG) || (m_phase == M_SECOND)};
    endtask

    task automatic check_outputs(input string tag);
        logic [6:0] obs;
        obs = {press, release_ev, click, dbl_click, long_press, repeat_ev, held};
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, m_now, obs, exp_v);
        end
        n_press += int'(press);
        n_rel   += int'(release_ev);
        n_click += int'(click);
        n_dbl   += int'(dbl_click);
        n_long  += int'(long_press);
        n_rpt   += int'(repeat_ev);
    endtask

    task automatic check_count(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic clear_counts();
        n_press = 0; n_rel = 0; n_click = 0; n_dbl = 0; n_long = 0; n_rpt = 0;
    endtask

    // Hold the key level (0 = pressed) for the given number of cycles.
    task automatic drive(input logic level, input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            in = level;
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_outputs(tag);
        end
    endtask

    task automatic apply_reset(input int cycles);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("reset_async");
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_outputs("in_reset");
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        in    = 1'b1;
        model_reset();
        clear_counts();
        @(negedge clk);
        apply_reset(3);
        drive(1'b1, 4, "idle");

        // Short single press -> click after the gap window.
        clear_counts();
        drive(1'b0, 5, "single_hold");
        drive(1'b1, 20, "single_gap");
        check_count("single_press_cnt", n_press, 1);
        check_count("single_click_cnt", n_click, 1);
        check_count("single_long_cnt", n_long, 0);

        // Double click.
        clear_counts();
        drive(1'b0, 3, "dbl_p1");
        drive(1'b1, 4, "dbl_gap");
        drive(1'b0, 3, "dbl_p2");
        drive(1'b1, 20, "dbl_rel");
        check_count("dbl_press_cnt", n_press, 2);
        check_count("dbl_dbl_cnt", n_dbl, 1);
        check_count("dbl_click_cnt", n_click, 0);

        // Long hold with auto-repeat.
        clear_counts();
        drive(1'b0, 30, "long_hold");
        drive(1'b1, 20, "long_rel");
        check_count("long_long_cnt", n_long, 1);
        check_count("long_rpt_cnt", n_rpt, 3);
        check_count("long_click_cnt", n_click, 0);

        // Release lands exactly on the long threshold.
        clear_counts();
        drive(1'b0, 16, "thr_hold");
        drive(1'b1, 20, "thr_rel");
        check_count("thr_long_cnt", n_long, 0);
        check_count("thr_click_cnt", n_click, 1);

        // Second press lands exactly on gap expiry.
        clear_counts();
        drive(1'b0, 3, "gapedge_p1");
        drive(1'b1, 8, "gapedge_gap");
        drive(1'b0, 3, "gapedge_p2");
        drive(1'b1, 20, "gapedge_rel");
        check_count("gapedge_click_cnt", n_click, 0);
        check_count("gapedge_dbl_cnt", n_dbl, 1);

        // Reset in the middle of a hold, key kept pressed.
        clear_counts();
        drive(1'b0, 6, "rst_hold");
        in = 1'b0;
        apply_reset(3);
        drive(1'b0, 20, "rst_after");
        drive(1'b1, 12, "rst_rel");
        check_count("rst_press_cnt", n_press, 2);
        check_count("rst_long_cnt", n_long, 1);

        // Reset in the middle of a gap: no click afterwards.
        clear_counts();
        drive(1'b0, 3, "rstgap_hold");
        drive(1'b1, 3, "rstgap_gap");
        in = 1'b1;
        apply_reset(2);
        drive(1'b1, 15, "rstgap_after");
        check_count("rstgap_click_cnt", n_click, 0);

        // Random runs of pressed/released levels.
        for (int r = 0; r < 120; r++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 22)), "random");
        end
        drive(1'b1, 30, "final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
